// File: rtl/alu_bitserial_seq_pkg.sv
// Shared encodings for the bit-serial ALU: control codes, slice ops, FSM states
// and the control-code decode used by the sequencer.
package alu_bitserial_seq_pkg;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_NAND = 4'b1101;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_LESS = 2'b01,
        OP_OR   = 2'b10,
        OP_ADD  = 2'b11
    } slice_op_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // How the final flags and result are formed once the last bit is through.
    typedef enum logic [1:0] {K_LOGIC, K_ARITH, K_SLT, K_BAD} kind_e;

    typedef struct packed {
        logic      ainv;
        logic      binv;
        slice_op_e op;
        kind_e     kind;
    } slice_ctl_t;

    function automatic logic init_carry(input logic [3:0] c);
        return (c == CTL_SUB) || (c == CTL_SLT);
    endfunction

    function automatic slice_ctl_t decode_ctl(input logic [3:0] c);
        slice_ctl_t d;
        d = '{ainv: 1'b0, binv: 1'b0, op: OP_AND, kind: K_BAD};
        case (c)
            CTL_AND:  d.kind = K_LOGIC;
            CTL_OR:   begin d.op = OP_OR;  d.kind = K_LOGIC; end
            CTL_ADD:  begin d.op = OP_ADD; d.kind = K_ARITH; end
            CTL_SUB:  begin d.binv = 1'b1; d.op = OP_ADD; d.kind = K_ARITH; end
            CTL_SLT:  begin d.binv = 1'b1; d.op = OP_ADD; d.kind = K_SLT; end
            CTL_NOR:  begin d.ainv = 1'b1; d.binv = 1'b1; d.kind = K_LOGIC; end
            CTL_NAND: begin d.ainv = 1'b1; d.binv = 1'b1; d.op = OP_OR; d.kind = K_LOGIC; end
            default:  ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_bitserial_seq_if.sv
// Request/response bundle of the bit-serial ALU.
interface alu_bitserial_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ALU_control;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (output start, src1, src2, ALU_control,
                    input  busy, done, result, zero, cout, overflow);
    modport slave  (input  start, src1, src2, ALU_control,
                    output busy, done, result, zero, cout, overflow);
endinterface

// File: rtl/alu_bitserial_seq_alu_1bit.sv
// One-bit ALU slice: optional operand inversion, and/or/add with ripple carry,
// plus the Less pass-through.
module ALU_1bit
    import alu_bitserial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       CarryIn,
    input  logic       Less,
    input  logic [1:0] operation,
    output logic       Result,
    output logic       CarryOut
);
    logic aa, bb;

    assign aa       = a ^ Ainvert;
    assign bb       = b ^ Binvert;
    assign CarryOut = (aa & bb) | (aa & CarryIn) | (bb & CarryIn);

    always_comb begin
        Result = aa ^ bb ^ CarryIn;
        case (operation)
            OP_AND:  Result = aa & bb;
            OP_LESS: Result = Less;
            OP_OR:   Result = aa | bb;
            default: Result = aa ^ bb ^ CarryIn;
        endcase
    end
endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial WIDTH-bit ALU: latches operands, walks one ALU_1bit slice LSB first
// with the carry kept in a flop, then publishes result and flags for one done cycle.
module alu_bitserial_seq
    import alu_bitserial_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_bitserial_seq_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, acc;
    logic [3:0]       ctl_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             last;
    slice_ctl_t       dec_q;
    logic             s_res, s_cout;

    logic [WIDTH-1:0] acc_nxt, res_fin;
    logic             fin_cout, fin_ovf, slt_set;

    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q;

    assign dec_q = decode_ctl(ctl_q);
    assign last  = (idx == IDX_W'(WIDTH - 1));

    ALU_1bit u_slice (
        .a         (a_q[idx]),
        .b         (b_q[idx]),
        .Ainvert   (dec_q.ainv),
        .Binvert   (dec_q.binv),
        .CarryIn   (carry_q),
        .Less      (1'b0),
        .operation (dec_q.op),
        .Result    (s_res),
        .CarryOut  (s_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last)      state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Final-bit view: on the last RUN edge carry_q is the carry into the MSB
    // and s_cout the carry out of it, so overflow is their xor.
    always_comb begin
        acc_nxt  = {s_res, acc[WIDTH-1:1]};
        slt_set  = s_res ^ carry_q ^ s_cout;
        res_fin  = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        case (dec_q.kind)
            K_LOGIC: res_fin = acc_nxt;
            K_ARITH: begin
                res_fin  = acc_nxt;
                fin_cout = s_cout;
                fin_ovf  = carry_q ^ s_cout;
            end
            K_SLT:   res_fin = {{(WIDTH-1){1'b0}}, slt_set};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            idx      <= '0;
            carry_q  <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    a_q     <= bus.src1;
                    b_q     <= bus.src2;
                    ctl_q   <= bus.ALU_control;
                    carry_q <= init_carry(bus.ALU_control);
                    idx     <= '0;
                end
                S_RUN: begin
                    acc     <= acc_nxt;
                    carry_q <= s_cout;
                    if (last) begin
                        result_q <= res_fin;
                        zero_q   <= (res_fin == '0);
                        cout_q   <= fin_cout;
                        ovf_q    <= fin_ovf;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
